spi_reg_master: RTL
===================

# spi_reg_master

Clock-domain SPI mode-0 master that issues single register transactions to the FPGA's SPI register slave. Each frame is one RnW bit, an ASZ-bit address and a DSZ-bit data word, all MSB first. The block lets on-board logic and loopback benches read and write the register file over the same wire protocol the external host uses. It generates SCK from `clk` and enforces the chip-select and turnaround gaps that the slave's clock-domain strobe generation needs.

## Interface
- `ASZ`, 7, address width.
- `DSZ`, 32, data width.
- `CLK_DIV`, 2, SCK half-period in `clk` cycles; ≥1.
- `CS_SETUP`, 2, `clk` cycles from ncs fall to the start of bit 0's low phase; ≥1.
- `RD_GAP`, 8, extra `clk` cycles that the SCK high phase of the last address bit is stretched on reads; ≥0.
- `CS_HOLD`, 8, `clk` cycles from the last SCK fall to ncs rise; ≥1.
- `CS_IDLE`, 2, `clk` cycles ncs stays high before the next frame may start; ≥1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request; accepted only when `busy`=0.
- `rnw` in 1: 1 = read, 0 = write; sampled on accept.
- `addr` in ASZ: register address; sampled on accept.
- `wdata` in DSZ: write data; sampled on accept.
- `busy` out 1: high from the cycle after accept until idle gap ends.
- `done` out 1: 1-cycle pulse at frame end.
- `rdata` out DSZ: read data; valid from `done` until the next read `done`.
- `spi_sck` out 1: serial clock; idles low.
- `spi_mosi` out 1: master out.
- `spi_miso` in 1: master in.
- `spi_ncs` out 1: chip select, active low.

## Operation
- States: IDLE, SETUP, LOW, HIGH, GAP, HOLD, DESEL.
- IDLE: `start`=1 latches rnw/addr/wdata into a 1+ASZ+DSZ shift register. Next cycle: `busy`=1, `spi_ncs`=0, `spi_mosi`=RnW bit, state SETUP.
- SETUP: CS_SETUP cycles, SCK low, then LOW.
- LOW: CLK_DIV cycles, SCK=0, `spi_mosi` = current bit; then HIGH.
- HIGH: CLK_DIV cycles, SCK=1. Entry cycle = rising edge; MISO is sampled per Configuration.
  - If this is bit index ASZ (last address bit) and the frame is a read, go to GAP after HIGH.
  - Else if bits remain, advance the shifter and go to LOW.
  - Else go to HOLD.
- GAP: RD_GAP cycles, SCK held high; then LOW of bit ASZ+1. With RD_GAP=0, GAP is skipped.
- HOLD: SCK=0, CS_HOLD cycles; then `spi_ncs`=1, `done`=1 for one cycle, state DESEL.
- DESEL: CS_IDLE cycles (including the `done` cycle), then `busy`=0, state IDLE.
- Bit index counter: $clog2(1+ASZ+DSZ+1) bits. Phase timer wide enough for max(CLK_DIV, CS_SETUP, RD_GAP, CS_HOLD, CS_IDLE).
- MOSI during data bits of a read is 0.
- `rdata` shifts in MISO samples for bit indices ASZ+1..ASZ+DSZ only. It updates at `done` on reads and holds on writes.
- `start` while `busy`=1 is ignored; there is no queueing.
- `rst` asserted: `spi_ncs`=1, `spi_sck`=0, `spi_mosi`=0, `busy`=0, `done`=0, `rdata`=0, state IDLE, immediately, including mid-frame. An aborted frame produces no `done`.

## Timing
- Accept cycle T. ncs falls at T+1. First SCK rise at T+1+CS_SETUP+CLK_DIV.
- ncs low duration: CS_SETUP + 2·CLK_DIV·(1+ASZ+DSZ) + CS_HOLD, plus RD_GAP on reads. Defaults: write 170 cycles, read 178 cycles.
- `done` coincides with the first cycle of ncs high. `busy` falls CS_IDLE cycles after ncs rises. Earliest next accept is the cycle after `busy` falls.
- MOSI changes only in cycles where SCK is low, never at a rising edge.

## Configuration
- `SPI_REG_MASTER_MISO_SYNC_EN` defined:
  - `spi_miso` passes through a 2-flop synchronizer.
  - The sample is taken on the last cycle of each HIGH phase (last GAP cycle is not used; GAP precedes sampling bits).
  - Requires CLK_DIV≥2.
- Not defined: `spi_miso` is sampled directly on the HIGH entry cycle.
- Frame timing is identical in both cases.

## Test plan
- Write addr 0x15, wdata 0xDEADBEEF, defaults → MOSI bits 0,0010101,DEADBEEF MSB-first on 40 rising edges; ncs low 170 cycles; one `done`; `rdata` unchanged.
- Read addr 0x7F; model slave drives 0x12345678 starting at the SCK fall after address bit 7 → SCK high for 2+8 cycles after the 8th rise; `rdata`=0x12345678 at `done`; ncs low 178 cycles.
- `start` held high continuously → frames separated by exactly CS_IDLE ncs-high cycles plus the 1 accept cycle; extra starts during `busy` produce no extra frames.
- `rst` pulsed at the 20th SCK rise → ncs=1, sck=0 in the same cycle; no `done`; a following write completes normally.
- CLK_DIV=1, RD_GAP=0, both macro settings (macro build with CLK_DIV=2) → read returns 0xA5A5A5A5 correctly; SCK period is 2·CLK_DIV cycles.

Source files
------------

// File: rtl/spi_reg_master.sv
// spi_reg_master -- SPI mode-0 master issuing single register transactions.
//
// Frame: RnW bit, ASZ-bit address, DSZ-bit data, all MSB first. SCK is
// derived from clk (CLK_DIV clk cycles per half period). Chip-select setup,
// hold and idle gaps are enforced, and on reads the high phase of the last
// address bit is stretched by RD_GAP cycles so the slave can fetch the word.
//
// Optional feature macro: SPI_REG_MASTER_MISO_SYNC_EN
//   defined   : spi_miso passes a 2-flop synchronizer and is sampled on the
//               last cycle of each HIGH phase (needs CLK_DIV >= 2).
//   undefined : spi_miso is sampled directly on the HIGH entry cycle.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   start, rnw, addr,    transaction request (accepted only when busy = 0)
//   wdata
//   busy                 high from the cycle after accept until idle gap ends
//   done                 one-cycle pulse at frame end (first ncs-high cycle)
//   rdata                read data, updated at done of a read
//   spi_sck, spi_mosi,   SPI bus (sck idles low, ncs active low)
//   spi_miso, spi_ncs
module spi_reg_master #(
  parameter int ASZ      = 7,
  parameter int DSZ      = 32,
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int RD_GAP   = 8,
  parameter int CS_HOLD  = 8,
  parameter int CS_IDLE  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           rnw,
  input  logic [ASZ-1:0] addr,
  input  logic [DSZ-1:0] wdata,
  output logic           busy,
  output logic           done,
  output logic [DSZ-1:0] rdata,
  output logic           spi_sck,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic           spi_ncs
);

  localparam int FL   = 1 + ASZ + DSZ;
  localparam int BW   = $clog2(FL + 1);
  localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2   = (M1 > RD_GAP) ? M1 : RD_GAP;
  localparam int M3   = (M2 > CS_HOLD) ? M2 : CS_HOLD;
  localparam int TMAX = (M3 > CS_IDLE) ? M3 : CS_IDLE;
  // The timer counts down from (phase length - 1) to 0.
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] T_DIV   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] T_GAP   = TW'((RD_GAP > 0) ? RD_GAP - 1 : 0);
  localparam logic [TW-1:0] T_HOLD  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] T_IDLE  = TW'(CS_IDLE - 1);

  localparam logic [BW-1:0] B_LAST_ADDR  = BW'(ASZ);
  localparam logic [BW-1:0] B_FIRST_DATA = BW'(ASZ + 1);
  localparam logic [BW-1:0] B_LAST       = BW'(FL - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP, HOLD, DESEL} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [BW-1:0]   bit_reg, bit_next;
  logic [FL-1:0]   shift_reg, shift_next;
  logic            read_reg, read_next;
  logic [DSZ-1:0]  rx_reg;
  logic            done_next;
  logic            timer_zero;
  logic            sample_en;
  logic            miso_bit;
  logic            sel_next;

  assign timer_zero = (timer_reg == '0);

`ifdef SPI_REG_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miso_sync_reg <= 2'b00;
    else     miso_sync_reg <= {miso_sync_reg[0], spi_miso};
  end

  assign miso_bit  = miso_sync_reg[1];
  // Last HIGH cycle: gives the synchronizer time to settle after the fall.
  assign sample_en = (state_reg == HIGH) && timer_zero;
`else
  assign miso_bit  = spi_miso;
  // HIGH entry cycle: the timer was just loaded with T_DIV.
  assign sample_en = (state_reg == HIGH) && (timer_reg == T_DIV);
`endif

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    read_next  = read_reg;
    done_next  = 1'b0;
    if (state_reg != IDLE && !timer_zero) begin
      timer_next = timer_reg - 1'b1;
    end
    case (state_reg)
      IDLE: begin
        if (start) begin
          // Data field is zeroed on reads so MOSI stays low during data bits.
          shift_next = {rnw, addr, (rnw ? {DSZ{1'b0}} : wdata)};
          read_next  = rnw;
          bit_next   = '0;
          timer_next = T_SETUP;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (timer_zero) begin
          timer_next = T_DIV;
          state_next = LOW;
        end
      end
      LOW: begin
        if (timer_zero) begin
          timer_next = T_DIV;
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (timer_zero) begin
          if (read_reg && (bit_reg == B_LAST_ADDR) && (RD_GAP > 0)) begin
            timer_next = T_GAP;
            state_next = GAP;
          end else if (bit_reg != B_LAST) begin
            // Shift on the way into LOW so MOSI only moves while SCK is low.
            shift_next = shift_reg << 1;
            bit_next   = bit_reg + 1'b1;
            timer_next = T_DIV;
            state_next = LOW;
          end else begin
            timer_next = T_HOLD;
            state_next = HOLD;
          end
        end
      end
      GAP: begin
        if (timer_zero) begin
          shift_next = shift_reg << 1;
          bit_next   = bit_reg + 1'b1;
          timer_next = T_DIV;
          state_next = LOW;
        end
      end
      HOLD: begin
        if (timer_zero) begin
          done_next  = 1'b1;
          timer_next = T_IDLE;
          state_next = DESEL;
        end
      end
      DESEL: begin
        if (timer_zero) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sel_next = (state_next != IDLE) && (state_next != DESEL);

  // Bus outputs are registered from the next-state decode so they are
  // glitch-free and still change in the same cycle the state does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      read_reg  <= 1'b0;
      rx_reg    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      spi_sck   <= 1'b0;
      spi_ncs   <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      read_reg  <= read_next;
      if (sample_en && read_reg && (bit_reg >= B_FIRST_DATA)) begin
        rx_reg <= {rx_reg[DSZ-2:0], miso_bit};
      end
      if (done_next && read_reg) begin
        rdata <= rx_reg;
      end
      busy     <= (state_next != IDLE);
      done     <= done_next;
      spi_sck  <= (state_next == HIGH) || (state_next == GAP);
      spi_ncs  <= !sel_next;
      spi_mosi <= sel_next && shift_next[FL-1];
    end
  end

endmodule
